i2c_slave: RTL and testbench

I2C target (responder) for the tag's on-chip register bus; it answers the existing I2C master controller on the same two-wire bus. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a fixed 7-bit address, and ACKs. Written bytes are handed to local logic, and read bytes are fetched from local logic through simple strobe handshakes. No clock stretching; SCL is input-only.

---
 rtl/i2c_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target answering a fixed 7-bit address on the register bus.
// SCL/SDA are oversampled with clk. Write bytes are presented on rx_data with
// an rx_valid strobe; read bytes are requested with a tx_req strobe. SDA is
// open-drain and SCL is never stretched.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | bus idle or after reset, waiting for START
// S_ADDR      | shifting in address + R/W byte
// S_ADDR_ACK  | holding SDA low for the address ACK
// S_RX_BYTE   | shifting in a write data byte
// S_RX_ACK    | holding SDA low for the data ACK
// S_TX_BYTE   | driving a read data byte, MSB first
// S_TX_ACK    | SDA released, sampling the master's ACK/NACK
// S_WAIT_STOP | not addressed or NACKed, ignoring the bus until START/STOP
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        byte_full, byte_full_nxt;
  logic        sda_oe, sda_oe_nxt;
  logic [7:0]  rx_data_nxt;
  logic        rx_valid_nxt;
  logic        tx_req_nxt;
  logic        busy_nxt;

  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shift_in;

  // Open-drain pad: only ever pull low or let the bus pull-up win.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronize the bus pins and keep one delayed copy for edge detection.
  // Reset to the idle-bus level so releasing reset never fakes a START.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign shift_in  = {shreg[6:0], sda_s2};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      byte_full <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      byte_full <= byte_full_nxt;
      sda_oe    <= sda_oe_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic. byte_full marks "8 bits taken, waiting for the SCL fall
  // that starts the ACK slot" so the counter can simply wrap 7 -> 0.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    byte_full_nxt = byte_full;
    sda_oe_nxt    = sda_oe;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    busy_nxt      = busy;

    if (start_det) begin
      state_nxt     = S_ADDR;
      bit_cnt_nxt   = 3'd0;
      byte_full_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else if (stop_det) begin
      state_nxt     = S_IDLE;
      bit_cnt_nxt   = 3'd0;
      byte_full_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                byte_full_nxt = 1'b1;
                tx_req_nxt    = shift_in[0];
              end else begin
                state_nxt = S_WAIT_STOP;
              end
            end
          end else if (scl_fall && byte_full) begin
            byte_full_nxt = 1'b0;
            sda_oe_nxt    = 1'b1;
            busy_nxt      = 1'b1;
            state_nxt     = S_ADDR_ACK;
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = 3'd0;
            if (shreg[0]) begin
              shreg_nxt  = tx_data;
              sda_oe_nxt = ~tx_data[7];
              state_nxt  = S_TX_BYTE;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = S_RX_BYTE;
            end
          end
        end

        S_RX_BYTE: begin
          if (scl_rise) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nxt   = shift_in;
              rx_valid_nxt  = 1'b1;
              byte_full_nxt = 1'b1;
            end
          end else if (scl_fall && byte_full) begin
            byte_full_nxt = 1'b0;
            sda_oe_nxt    = 1'b1;
            state_nxt     = S_RX_ACK;
          end
        end

        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = S_RX_BYTE;
          end
        end

        S_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              state_nxt   = S_TX_ACK;
            end else begin
              shreg_nxt   = {shreg[6:0], 1'b0};
              sda_oe_nxt  = ~shreg[6];
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end

        S_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              tx_req_nxt    = 1'b1;
              byte_full_nxt = 1'b1;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = S_WAIT_STOP;
            end
          end else if (scl_fall && byte_full) begin
            byte_full_nxt = 1'b0;
            shreg_nxt     = tx_data;
            sda_oe_nxt    = ~tx_data[7];
            bit_cnt_nxt   = 3'd0;
            state_nxt     = S_TX_BYTE;
          end
        end

        S_WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
        end

        default: begin
          state_nxt  = S_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: acts as the bus master, bit-banging SCL/SDA
// slowly relative to clk, and watches the strobe outputs with a monitor.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_drv = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int rx_cnt = 0;
  int tx_cnt = 0;
  int slave_low_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic width_err = 1'b0;
  logic overlap_err = 1'b0;
  logic rxv_q = 1'b0;
  logic txr_q = 1'b0;

  pullup (sda);
  assign sda = m_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  // Strobe / bus monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
    if (tx_req) tx_cnt = tx_cnt + 1;
    if ((rx_valid && rxv_q) || (tx_req && txr_q)) width_err = 1'b1;
    if (rx_valid && tx_req) overlap_err = 1'b1;
    rxv_q = rx_valid;
    txr_q = tx_req;
    if (!m_drv && sda === 1'b0) slave_low_cnt = slave_low_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; enters and leaves with SCL low. b=1 releases SDA.
  task automatic bit_x(input logic b, output logic s);
    wait_clk(2);
    m_drv = ~b;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(5);
    s = sda;
    wait_clk(5);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(2);
    m_drv = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(5);
    m_drv = 1'b1;
    wait_clk(5);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);
    m_drv = 1'b1;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(5);
    m_drv = 1'b0;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(ack_bit, s);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] d;
    int rx_base, tx_base, low_base, busy_base;

    // Reset values
    wait_clk(5);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_clk(10);

    // Write 0xA5, 0x3C to 0x42
    rx_base = rx_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hA5, ack);
    chk("wr_d0_ack", {31'd0, ack}, 32'd0);
    chk("wr_d0_data", {24'd0, rx_last}, 32'hA5);
    send_byte(8'h3C, ack);
    chk("wr_d1_ack", {31'd0, ack}, 32'd0);
    chk("wr_d1_data", {24'd0, rx_last}, 32'h3C);
    chk("wr_rx_port", {24'd0, rx_data}, 32'h3C);
    i2c_stop();
    chk("wr_rx_count", rx_cnt - rx_base, 32'd2);
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read 0x96 (ACK) then 0x5A (NACK)
    tx_base = tx_cnt;
    rx_base = rx_cnt;
    tx_data = 8'h96;
    i2c_start();
    send_byte(8'h85, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    chk("rd_d0", {24'd0, d}, 32'h96);
    tx_data = 8'h5A;
    bit_x(1'b0, s);
    recv_byte(1'b1, d);
    chk("rd_d1", {24'd0, d}, 32'h5A);
    chk("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    chk("rd_tx_count", tx_cnt - tx_base, 32'd2);
    low_base = slave_low_cnt;
    send_byte(8'hFF, ack);
    chk("rd_wait_stop_ack", {31'd0, ack}, 32'd1);
    chk("rd_wait_stop_drive", slave_low_cnt - low_base, 32'd0);
    i2c_stop();
    chk("rd_rx_count", rx_cnt - rx_base, 32'd0);

    // Address mismatch
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    low_base = slave_low_cnt;
    busy_base = busy_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    chk("mm_addr_nack", {31'd0, ack}, 32'd1);
    send_byte(8'hFF, ack);
    chk("mm_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("mm_no_drive", slave_low_cnt - low_base, 32'd0);
    chk("mm_no_rx", rx_cnt - rx_base, 32'd0);
    chk("mm_no_tx", tx_cnt - tx_base, 32'd0);
    chk("mm_no_busy", busy_cnt - busy_base, 32'd0);

    // Repeated START: write 0x11, then read 0x22 with NACK
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    tx_data = 8'h22;
    i2c_start();
    send_byte(8'h84, ack);
    chk("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h11, ack);
    chk("rs_wr_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    send_byte(8'h85, ack);
    chk("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
    recv_byte(1'b1, d);
    chk("rs_rd_data", {24'd0, d}, 32'h22);
    i2c_stop();
    chk("rs_rx_data", {24'd0, rx_data}, 32'h11);
    chk("rs_rx_count", rx_cnt - rx_base, 32'd1);
    chk("rs_tx_count", tx_cnt - tx_base, 32'd1);

    // Abort after 4 data bits, then a normal write
    rx_base = rx_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    chk("ab_addr_ack", {31'd0, ack}, 32'd0);
    bit_x(1'b1, s);
    bit_x(1'b0, s);
    bit_x(1'b1, s);
    bit_x(1'b0, s);
    i2c_stop();
    chk("ab_no_rx", rx_cnt - rx_base, 32'd0);
    chk("ab_sda_released", {31'd0, sda}, 32'd1);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    send_byte(8'h84, ack);
    chk("ab2_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h77, ack);
    chk("ab2_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("ab2_rx_data", {24'd0, rx_last}, 32'h77);
    chk("ab2_rx_count", rx_cnt - rx_base, 32'd1);

    // Reset while the slave is holding the address ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h84;
      bit_x(a[i], s);
    end
    wait_clk(2);
    m_drv = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(3);
    chk("rr_ack_held", {31'd0, sda}, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_sda_released", {31'd0, sda}, 32'd1);
    chk("rr_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rr_tx_req", {31'd0, tx_req}, 32'd0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    scl = 1'b0;
    wait_clk(5);
    i2c_stop();
    rx_base = rx_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    chk("rr2_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'hC3, ack);
    chk("rr2_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("rr2_rx_data", {24'd0, rx_last}, 32'hC3);
    chk("rr2_rx_count", rx_cnt - rx_base, 32'd1);

    // Strobe shape over the whole run
    chk("strobe_width", {31'd0, width_err}, 32'd0);
    chk("strobe_overlap", {31'd0, overlap_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
